serial_word_adder: RTL and testbench

//  Multi-lane bit-serial adder with per-lane overflow detection. Each lane takes two
//  LSB-first serial operands (line1/line2), emits the serial sum bit, and flags overflow at

---
 rtl/serial_word_adder.sv | 105 ++++++++++
 tb/tb_serial_word_adder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_adder.sv
// Multi-lane LSB-first serial adder with shared bit counter and per-lane overflow.
// Define OVF_STICKY_EN to make overflw sticky until ovf_clr.
module serial_word_adder #(
  parameter int CHANNELS  = 4,
  parameter int WORD_BITS = 8,
  parameter int SIGNED    = 0,
  localparam int IW = $clog2(WORD_BITS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                sync,
  input  logic [CHANNELS-1:0] line1,
  input  logic [CHANNELS-1:0] line2,
  input  logic                ovf_clr,
  output logic [CHANNELS-1:0] outp,
  output logic                out_valid,
  output logic                word_done,
  output logic [CHANNELS-1:0] overflw,
  output logic [IW-1:0]       bit_idx
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAST
  } state_t;

  state_t state, state_n;

  logic [IW-1:0]       cnt, cnt_n, pos;
  logic                msb;
  logic [CHANNELS-1:0] carry, carry_n;
  logic [CHANNELS-1:0] cin, sum, cout;
  logic [CHANNELS-1:0] ovf_bits, ovf_n;

  // Only RUN carries a live position; IDLE, LAST and sync all start at bit 0.
  always_comb begin
    pos = '0;
    if (state == RUN && !sync) pos = cnt;
    msb = (pos == IW'(WORD_BITS - 1));
    cin = (pos == '0) ? '0 : carry;
    sum = line1 ^ line2 ^ cin;
    cout = (line1 & line2) | (line1 & cin) | (line2 & cin);
    ovf_bits = (SIGNED != 0) ? (cin ^ cout) : cout;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    carry_n = carry;
    if (in_valid) begin
      carry_n = msb ? '0 : cout;
      if (msb) begin
        state_n = LAST;
        cnt_n   = '0;
      end else begin
        state_n = RUN;
        cnt_n   = pos + IW'(1);
      end
    end else if (state == LAST) begin
      state_n = IDLE;
    end
  end

`ifdef OVF_STICKY_EN
  always_comb begin
    ovf_n = ovf_clr ? '0 : overflw;
    if (in_valid && msb) ovf_n = ovf_n | ovf_bits;
  end
`else
  logic unused_clr;
  assign unused_clr = ovf_clr;

  always_comb begin
    ovf_n = '0;
    if (in_valid && msb) ovf_n = ovf_bits;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= '0;
      outp      <= '0;
      out_valid <= 1'b0;
      word_done <= 1'b0;
      overflw   <= '0;
      bit_idx   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      carry     <= carry_n;
      out_valid <= in_valid;
      word_done <= in_valid && msb;
      overflw   <= ovf_n;
      if (in_valid) begin
        outp    <= sum;
        bit_idx <= pos;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_adder.sv
// Bench for serial_word_adder: unsigned and signed instances against a word-level model.
// Build with OVF_STICKY_EN defined to exercise the sticky overflow flag.
module tb_serial_word_adder;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int IW = $clog2(W);

  logic clock = 1'b0;
  logic reset, in_valid, sync, ovf_clr;
  logic [CH-1:0] line1, line2;
  logic [CH-1:0] outp0, outp1, ovf0, ovf1;
  logic ov0, ov1, wd0, wd1;
  logic [IW-1:0] idx0, idx1;

  always #5 clock = ~clock;

  serial_word_adder #(.CHANNELS(CH), .WORD_BITS(W), .SIGNED(0)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .sync(sync),
    .line1(line1), .line2(line2), .ovf_clr(ovf_clr), .outp(outp0),
    .out_valid(ov0), .word_done(wd0), .overflw(ovf0), .bit_idx(idx0)
  );

  serial_word_adder #(.CHANNELS(CH), .WORD_BITS(W), .SIGNED(1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .sync(sync),
    .line1(line1), .line2(line2), .ovf_clr(ovf_clr), .outp(outp1),
    .out_valid(ov1), .word_done(wd1), .overflw(ovf1), .bit_idx(idx1)
  );

  int tests = 0;
  int fails = 0;

  int            mpos;
  logic [W-1:0]  ma [CH];
  logic [W-1:0]  mb [CH];
  logic [CH-1:0] e_outp, e_ovf0, e_ovf1;
  logic          e_ov, e_done;
  logic [IW-1:0] e_idx;
  bit            chk_en = 0;

  logic [W-1:0]  cap [CH];
  logic [CH*W-1:0] qw[$];
  logic [CH-1:0] qo0[$];
  logic [CH-1:0] qo1[$];
  int            nvalid = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    mpos = 0;
    for (int i = 0; i < CH; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    e_outp = '0;
    e_ovf0 = '0;
    e_ovf1 = '0;
    e_ov   = 1'b0;
    e_done = 1'b0;
    e_idx  = '0;
  endtask

  // Word-level model: operands accumulate per lane, outputs are bits of a+b.
  task automatic model_step(input logic iv, input logic sy,
                            input logic [CH-1:0] a, input logic [CH-1:0] b,
                            input logic clr);
    logic [W:0]    s;
    logic [CH-1:0] set0, set1;
    int            p;
    set0 = '0;
    set1 = '0;
    e_done = 1'b0;
    e_ov = iv;
    if (iv) begin
      p = sy ? 0 : mpos;
      for (int i = 0; i < CH; i++) begin
        if (p == 0) begin
          ma[i] = '0;
          mb[i] = '0;
        end
        ma[i][p] = a[i];
        mb[i][p] = b[i];
        s = {1'b0, ma[i]} + {1'b0, mb[i]};
        e_outp[i] = s[p];
        if (p == W - 1) begin
          set0[i] = s[W];
          set1[i] = (ma[i][W-1] == mb[i][W-1]) && (s[W-1] != ma[i][W-1]);
        end
      end
      e_idx  = IW'(p);
      e_done = (p == W - 1);
      mpos   = (p == W - 1) ? 0 : p + 1;
    end
`ifdef OVF_STICKY_EN
    e_ovf0 = (clr ? '0 : e_ovf0) | set0;
    e_ovf1 = (clr ? '0 : e_ovf1) | set1;
`else
    e_ovf0 = set0;
    e_ovf1 = set1;
    if (clr) e_ovf0 = e_ovf0;
`endif
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("outp_u", 32'(outp0), 32'(e_outp));
      chk("outp_s", 32'(outp1), 32'(e_outp));
      chk("out_valid_u", 32'(ov0), 32'(e_ov));
      chk("out_valid_s", 32'(ov1), 32'(e_ov));
      chk("word_done_u", 32'(wd0), 32'(e_done));
      chk("word_done_s", 32'(wd1), 32'(e_done));
      chk("bit_idx_u", 32'(idx0), 32'(e_idx));
      chk("bit_idx_s", 32'(idx1), 32'(e_idx));
      chk("overflw_u", 32'(ovf0), 32'(e_ovf0));
      chk("overflw_s", 32'(ovf1), 32'(e_ovf1));
    end
  end

  always @(negedge clock) begin
    logic [CH*W-1:0] w;
    if (ov0) begin
      nvalid++;
      for (int i = 0; i < CH; i++) cap[i][idx0] = outp0[i];
    end
    if (wd0) begin
      for (int i = 0; i < CH; i++) w[i*W +: W] = cap[i];
      qw.push_back(w);
      qo0.push_back(ovf0);
      qo1.push_back(ovf1);
    end
  end

  task automatic tick(input logic iv, input logic sy,
                      input logic [CH-1:0] a, input logic [CH-1:0] b,
                      input logic clr);
    in_valid = iv;
    sync     = sy;
    line1    = a;
    line2    = b;
    ovf_clr  = clr;
    @(posedge clock);
    model_step(iv, sy, a, b, clr);
    #1;
  endtask

  task automatic idle(input logic clr);
    tick(1'b0, 1'b0, '0, '0, clr);
  endtask

  task automatic send_word(input logic [CH*W-1:0] A, input logic [CH*W-1:0] B,
                           input logic sy, input int stall_after,
                           input int stall_len, input logic clr_msb);
    logic [CH-1:0] a, b;
    for (int k = 0; k < W; k++) begin
      for (int i = 0; i < CH; i++) begin
        a[i] = A[i*W + k];
        b[i] = B[i*W + k];
      end
      tick(1'b1, sy && k == 0, a, b, clr_msb && k == W - 1);
      if (k == stall_after)
        for (int j = 0; j < stall_len; j++)
          tick(1'b0, 1'(j % 2), CH'($urandom), CH'($urandom), 1'b0);
    end
  endtask

  function automatic logic [CH*W-1:0] rnd_word();
    logic [CH*W-1:0] r;
    for (int i = 0; i < CH; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  localparam logic [CH*W-1:0] T1A = {8'h10, 8'h03, 8'h00, 8'hC8};
  localparam logic [CH*W-1:0] T1B = {8'h20, 8'h04, 8'h00, 8'h64};

  initial begin
    int nv0, nq0;
    logic [CH*W-1:0] w;
    logic [W-1:0] l0;
    reset    = 1'b1;
    in_valid = 1'b0;
    sync     = 1'b0;
    ovf_clr  = 1'b0;
    line1    = '0;
    line2    = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outp", 32'(outp0), 32'h0);
    chk("reset_ovf", 32'(ovf0), 32'h0);
    reset  = 1'b0;
    chk_en = 1;
    idle(1'b0);

    // 200+100 on lane 0
    nv0 = nvalid;
    nq0 = qw.size();
    send_word(T1A, T1B, 1'b0, -1, 0, 1'b0);
    idle(1'b1);
    w = qw[$];
    l0 = w[W-1:0];
    chk("t1_sum", 32'(l0), 32'h2C);
    chk("t1_ovf_u", 32'(qo0[$]), 32'b0001);
    chk("t1_ovf_s", 32'(qo1[$]), 32'b0000);
    chk("t1_valid_cycles", 32'(nvalid - nv0), 32'd8);
    chk("t1_done_count", 32'(qw.size() - nq0), 32'd1);

    // 100+100 on lane 1
    send_word({8'h00, 8'h00, 8'h64, 8'h00}, {8'h00, 8'h00, 8'h64, 8'h00},
              1'b1, -1, 0, 1'b0);
    idle(1'b1);
    w = qw[$];
    chk("t2_sum", 32'(w[2*W-1:W]), 32'hC8);
    chk("t2_ovf_s", 32'(qo1[$][1]), 32'h1);
    chk("t2_ovf_u", 32'(qo0[$][1]), 32'h0);
    idle(1'b1);

    // back-to-back: carry must not leak into the second word
    nq0 = qw.size();
    send_word({24'h0, 8'hFF}, {24'h0, 8'h01}, 1'b0, -1, 0, 1'b0);
    send_word({24'h0, 8'h01}, {24'h0, 8'h01}, 1'b0, -1, 0, 1'b0);
    idle(1'b0);
    chk("t3_words", 32'(qw.size() - nq0), 32'd2);
    w = qw[nq0];
    chk("t3_sum_a", 32'(w[W-1:0]), 32'h00);
    chk("t3_ovf_a", 32'(qo0[nq0][0]), 32'h1);
    w = qw[nq0+1];
    chk("t3_sum_b", 32'(w[W-1:0]), 32'h02);
`ifndef OVF_STICKY_EN
    chk("t3_ovf_b", 32'(qo0[nq0+1][0]), 32'h0);
`endif
    idle(1'b1);

    // stall for 3 cycles after bit 3
    nv0 = nvalid;
    send_word(T1A, T1B, 1'b0, 3, 3, 1'b0);
    idle(1'b0);
    w = qw[$];
    chk("t4_sum", 32'(w[W-1:0]), 32'h2C);
    chk("t4_valid_cycles", 32'(nvalid - nv0), 32'd8);
    idle(1'b1);

    // sync at bit 5 drops the partial word
    nq0 = qw.size();
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, 4'hF, 4'hF, 1'b0);
    send_word(T1A, T1B, 1'b1, -1, 0, 1'b0);
    idle(1'b0);
    chk("t5_done_count", 32'(qw.size() - nq0), 32'd1);
    w = qw[$];
    chk("t5_sum", 32'(w[W-1:0]), 32'h2C);

    // reset mid-word
    for (int k = 0; k < 3; k++)
      tick(1'b1, 1'b0, CH'({T1A[24+k], T1A[16+k], T1A[8+k], T1A[k]}),
           CH'({T1B[24+k], T1B[16+k], T1B[8+k], T1B[k]}), 1'b0);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_outp", 32'(outp0), 32'h0);
    chk("rst_valid", 32'(ov0), 32'h0);
    chk("rst_idx", 32'(idx0), 32'h0);
    chk("rst_done", 32'(wd0), 32'h0);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    send_word(T1A, T1B, 1'b0, -1, 0, 1'b0);
    idle(1'b0);
    w = qw[$];
    chk("post_rst_sum", 32'(w[W-1:0]), 32'h2C);

`ifdef OVF_STICKY_EN
    idle(1'b1);
    send_word({24'h0, 8'hFF}, {24'h0, 8'h01}, 1'b0, -1, 0, 1'b0);
    send_word({24'h0, 8'h01}, {24'h0, 8'h01}, 1'b0, -1, 0, 1'b0);
    send_word({24'h0, 8'h02}, {24'h0, 8'h01}, 1'b0, -1, 0, 1'b0);
    idle(1'b0);
    chk("t6_sticky", 32'(ovf0[0]), 32'h1);
    idle(1'b1);
    chk("t6_cleared", 32'(ovf0[0]), 32'h0);
    send_word({24'h0, 8'hFF}, {24'h0, 8'h01}, 1'b0, -1, 0, 1'b1);
    chk("t6_set_wins", 32'(ovf0[0]), 32'h1);
    idle(1'b1);
`endif

    // randomized traffic: gaps, stalls, realigning syncs, clears
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        int m;
        m = $urandom_range(1, W - 1);
        for (int k = 0; k < m; k++)
          tick(1'b1, 1'b0, CH'($urandom), CH'($urandom), 1'b0);
        send_word(rnd_word(), rnd_word(), 1'b1, -1, 0, 1'($urandom));
      end else begin
        send_word(rnd_word(), rnd_word(), 1'($urandom_range(0, 3) == 0),
                  $urandom_range(0, 2) == 0 ? $urandom_range(0, W - 1) : -1,
                  $urandom_range(1, 3), 1'($urandom_range(0, 3) == 0));
      end
      for (int g = $urandom_range(0, 2); g > 0; g--)
        tick(1'b0, 1'($urandom), CH'($urandom), CH'($urandom),
             1'($urandom_range(0, 2) == 0));
    end
    idle(1'b0);
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
